msb_normalizer: RTL and testbench

//  Consumer stage directly downstream of the max/MSB finder in the attention path.

---
 rtl/msb_normalizer_if.sv | 27 ++
 rtl/msb_normalizer.sv | 145 ++++++++++++++
 tb/tb_msb_normalizer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/msb_normalizer_if.sv
// Output stream of the MSB normalizer: one scaled score per beat.
// The normalizer drives the master side; the softmax/exp stage is the slave.
interface msb_normalizer_if #(
  parameter int OUT_WIDTH = 4,
  parameter int N         = 4
);
  localparam int IW = $clog2(N) + 1;

  logic signed [OUT_WIDTH-1:0] out_data;
  logic [IW-1:0]               out_idx;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/msb_normalizer.sv
// Rescales N signed scores by one rounded arithmetic shift chosen from the
// max's MSB index, then streams them out one per cycle on valid/ready.
module msb_normalizer #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int OUT_WIDTH = 4,
  localparam int MIW      = $clog2(WIDTH) + 1,
  localparam int IW       = $clog2(N) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N-1:0][WIDTH-1:0]    In,
  input  logic [MIW-1:0]             msb_index,
  output logic                       busy,
  output logic                       done,
  msb_normalizer_if.master           ob
);

  localparam int EW  = WIDTH + 2;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;
  localparam int SHW = MIW + 1;

  localparam logic signed [EW-1:0] MAXV =
    EW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] MINV =
    EW'(-(1 << (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  state_t                      state_q, state_d;
  logic [N-1:0][WIDTH-1:0]     data_buf_q, data_buf_d;
  logic [SHW-1:0]              sh_q, sh_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]               out_idx_q, out_idx_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [IW-1:0]  idx_nxt;
  logic [SHW-1:0] msb_ext;
  logic           hs;
  logic           last;

  // Round half up, then clamp into the signed output range.
  function automatic logic signed [OUT_WIDTH-1:0] norm(
    input logic [WIDTH-1:0] x,
    input logic [SHW-1:0]   s
  );
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] r;
    xe  = {{2{x[WIDTH-1]}}, x};
    rnd = '0;
    if (s != '0)
      rnd = EW'(1) << (s - SHW'(1));
    r = (xe + rnd) >>> s;
    if (r > MAXV)
      r = MAXV;
    else if (r < MINV)
      r = MINV;
    return OUT_WIDTH'(r);
  endfunction

  always_comb begin
    state_d     = state_q;
    data_buf_d  = data_buf_q;
    sh_d        = sh_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    hs      = out_valid_q & ob.out_ready;
    last    = (out_idx_q == IW'(N - 1));
    idx_nxt = out_idx_q + IW'(1);
    msb_ext = SHW'(msb_index) + SHW'(2);

    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          data_buf_d = In;
          sh_d       = (msb_ext > SHW'(OUT_WIDTH)) ?
                       msb_ext - SHW'(OUT_WIDTH) : '0;
          busy_d     = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = norm(data_buf_q[0], sh_q);
        out_idx_d   = '0;
        out_valid_d = 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        if (hs) begin
          if (last) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            out_data_d = norm(data_buf_q[idx_nxt[SW-1:0]], sh_q);
            out_idx_d  = idx_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_buf_q  <= '0;
      sh_q        <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_buf_q  <= data_buf_d;
      sh_q        <= sh_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ob.out_data  = out_data_q;
  assign ob.out_idx   = out_idx_q;
  assign ob.out_valid = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_msb_normalizer.sv
// Randomized and directed bench for msb_normalizer against an
// arithmetic reference model of the rescale/round/saturate rule.
module tb_msb_normalizer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int OW = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [N-1:0][W-1:0] In;
  logic [3:0]       msb_index;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  msb_normalizer_if #(.OUT_WIDTH(OW), .N(N)) bus ();

  msb_normalizer #(
    .WIDTH(W),
    .N(N),
    .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .In(In),
    .msb_index(msb_index),
    .busy(busy),
    .done(done),
    .ob(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_f(input int x, input int msb);
    int sh;
    int d;
    int num;
    int r;
    int hi;
    int lo;
    sh = (msb + 2 > OW) ? msb + 2 - OW : 0;
    if (sh == 0) begin
      r = x;
    end else begin
      d   = 2 ** sh;
      num = x + d / 2;
      r   = num / d;
      if (num < 0 && (num % d) != 0)
        r = r - 1;
    end
    hi = 2 ** (OW - 1) - 1;
    lo = -(2 ** (OW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // MSB index as the upstream finder reports it for a given maximum.
  function automatic int msb_of(input int mx);
    int p;
    if (mx < 0) return W - 1;
    p = 0;
    while ((2 ** (p + 1)) <= mx) p++;
    return p;
  endfunction

  // mode: 0 always ready, 1 random ready, 2 stall 3 cycles at idx 1
  task automatic run_vec(
    input logic [N*W-1:0] vec,
    input int             msb,
    input int             mode,
    input bit             inj,
    input bit             rst_mid
  );
    int  ex[N];
    int  idx;
    int  cyc;
    int  stalls;
    int  first;
    int  last_hs;
    int  done_cyc;
    bit  fin;
    bit  rdy;
    bit  seen_done;
    for (int i = 0; i < N; i++)
      ex[i] = ref_f(int'($signed(vec[i*W +: W])), msb);
    idx = 0; stalls = 0; first = -1;
    last_hs = -1; done_cyc = -1; fin = 0;

    @(negedge clk);
    In = vec; msb_index = 4'(msb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("valid_in_load", int'(bus.out_valid), 0);
    @(negedge clk);
    cyc = 1;
    while (!fin) begin
      start = 1'b0;
      if (cyc > 200) begin
        chk("timeout", 1, 0);
        fin = 1;
      end else if (rst_mid && bus.out_valid && bus.out_idx == 3'd2) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(bus.out_idx), 0);
        seen_done = 0;
        repeat (8) begin
          @(negedge clk);
          if (done) seen_done = 1;
        end
        chk("no_done_after_rst", int'(seen_done), 0);
        fin = 1;
      end else begin
        if (mode == 0)
          rdy = 1'b1;
        else if (mode == 1)
          rdy = 1'($urandom_range(0, 1));
        else
          rdy = !(bus.out_valid && bus.out_idx == 3'd1 && stalls < 3);
        bus.out_ready = rdy;
        if (bus.out_valid) begin
          if (first < 0) begin
            first = cyc;
            chk("first_valid_lat", cyc, 1);
          end
          chk("idx", int'(bus.out_idx), idx);
          if (idx < N)
            chk("data", int'(bus.out_data), ex[idx]);
          if (rdy) begin
            idx++;
            last_hs = cyc;
          end else begin
            stalls++;
          end
        end
        if (done) begin
          done_cyc = cyc;
          chk("done_after_last_hs", cyc, last_hs + 1);
          chk("count", idx, N);
          chk("valid_at_done", int'(bus.out_valid), 0);
          chk("busy_at_done", int'(busy), 0);
          fin = 1;
        end else begin
          if (inj && cyc == 2) begin
            In = {N{8'd1}}; msb_index = 4'd0; start = 1'b1;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end

    if (!rst_mid && done_cyc >= 0) begin
      if (mode != 1)
        chk("done_cycle", done_cyc, N + 1 + stalls);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", int'(done), 0);
      chk("start_on_done_ignored", int'(busy), 0);
      @(negedge clk);
      chk("still_idle", int'(busy), 0);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(
    input int a, input int b, input int c, input int d
  );
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  logic [N*W-1:0] rv;
  int mx;
  int v;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    In = '0;
    msb_index = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_idx", int'(bus.out_idx), 0);
    chk("reset_data", int'(bus.out_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;

    run_vec(pack4(100, -50, 3, -128), 6, 0, 0, 0);
    run_vec(pack4(127, -1, 8, 0), 6, 0, 0, 0);
    run_vec(pack4(7, -100, 2, -8), 2, 0, 0, 0);
    run_vec(pack4(100, -50, 3, -128), 6, 2, 0, 0);
    run_vec(pack4(100, -50, 3, -128), 6, 0, 1, 0);
    run_vec(pack4(1, 1, 1, 1), 0, 0, 0, 0);
    run_vec(pack4(100, -50, 3, -128), 6, 0, 0, 1);
    run_vec(pack4(100, -50, 3, -128), 6, 0, 0, 0);
    run_vec(pack4(-3, -90, -128, -7), 7, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      mx = -1000;
      for (int i = 0; i < N; i++) begin
        v = int'($urandom_range(0, 255)) - 128;
        rv[i*W +: W] = 8'(v);
        if (v > mx) mx = v;
      end
      run_vec(rv, msb_of(mx), 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
